// File: rtl/dhcp_pkg.sv
// Shared DHCP/BOOTP constants, option codes and state types for the DHCP client transmit path.
package dhcp_pkg;

    localparam int DHCP_LEN = 300;

    localparam logic [7:0] BOOTP_OP_REQUEST = 8'h01;
    localparam logic [7:0] BOOTP_HTYPE_ETH  = 8'h01;
    localparam logic [7:0] BOOTP_HLEN_ETH   = 8'h06;
    localparam logic [7:0] BOOTP_FLAGS_BCAST = 8'h80;
    localparam logic [31:0] MAGIC_COOKIE    = 32'h6382_5363;

    localparam logic [7:0] OPT_MSG_TYPE   = 8'd53;
    localparam logic [7:0] OPT_REQ_IP     = 8'd50;
    localparam logic [7:0] OPT_SERVER_ID  = 8'd54;
    localparam logic [7:0] OPT_PARAM_LIST = 8'd55;
    localparam logic [7:0] OPT_END        = 8'd255;

    // Parameter request list: subnet mask, router, lease time
    localparam logic [7:0] PARAM_SUBNET = 8'd1;
    localparam logic [7:0] PARAM_ROUTER = 8'd3;
    localparam logic [7:0] PARAM_LEASE  = 8'd51;

    localparam logic [7:0] DHCP_DISCOVER = 8'd1;
    localparam logic [7:0] DHCP_REQUEST  = 8'd3;

    localparam logic [15:0] UDP_PORT_SERVER = 16'd67;
    localparam logic [15:0] UDP_PORT_CLIENT = 16'd68;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] XID_LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SEND, ST_DONE} send_state_t;
    typedef enum logic {MSG_DISCOVER, MSG_REQUEST} msg_t;

endpackage

// File: rtl/dhcp_send_if.sv
// Trigger, parameter and UDP tx handshake bundle between the network FSM, dhcp_send and the UDP sender.
interface dhcp_send_if;
    import dhcp_pkg::*;

    logic        send_discover;
    logic        send_request;
    logic [47:0] local_mac;
    logic [31:0] requested_ip;
    logic [31:0] server_ip;
    logic        tx_enable;
    logic        tx_next;
    logic        tx_request;
    logic [15:0] tx_length;
    logic [7:0]  tx_data;
    logic        active;
    logic        done;
    logic [31:0] xid;

    modport master (
        input  send_discover, send_request, local_mac, requested_ip, server_ip,
        input  tx_enable, tx_next,
        output tx_request, tx_length, tx_data, active, done, xid
    );

    modport slave (
        output send_discover, send_request, local_mac, requested_ip, server_ip,
        output tx_enable, tx_next,
        input  tx_request, tx_length, tx_data, active, done, xid
    );

endinterface

// File: rtl/dhcp_xid_lfsr.sv
// Free-running 32-bit Galois LFSR used as the DHCP transaction-ID source.
// Latency: new value every cycle. Backpressure: none, never stalls.
module dhcp_xid_lfsr
    import dhcp_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5C3_1E7B
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] value
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[31:1]} ^ (value[0] ? XID_LFSR_MASK : 32'h0);
        end
    end

endmodule

// File: rtl/dhcp_send.sv
// DHCP client transmit: streams a fixed-length DISCOVER/REQUEST payload to the UDP sender.
// Latency: tx_request one cycle after trigger; one byte per tx_next once granted.
// Backpressure: tx_next gates each byte; dropping tx_enable mid-stream aborts to idle.
module dhcp_send
    import dhcp_pkg::*;
#(
    parameter int          PAYLOAD_LEN = DHCP_LEN,
    parameter logic [31:0] XID_SEED    = 32'hA5C3_1E7B
) (
    input  logic        clock,
    input  logic        reset,
    dhcp_send_if.master bus
);

    localparam logic [8:0] LAST_IDX = 9'(PAYLOAD_LEN - 1);

    send_state_t state, state_nxt;
    msg_t        msg_q, msg_nxt;
    logic [8:0]  idx, idx_nxt;
    logic [31:0] xid_q, xid_nxt;
    logic [47:0] mac_q, mac_nxt;
    logic [31:0] rip_q, rip_nxt;
    logic [31:0] sip_q, sip_nxt;
    logic [31:0] lfsr_val;
    logic [7:0]  byte_val;

    dhcp_xid_lfsr #(.SEED(XID_SEED)) u_xid_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_val)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            msg_q <= MSG_DISCOVER;
            idx   <= 9'd0;
            xid_q <= 32'h0;
            mac_q <= 48'h0;
            rip_q <= 32'h0;
            sip_q <= 32'h0;
        end else begin
            state <= state_nxt;
            msg_q <= msg_nxt;
            idx   <= idx_nxt;
            xid_q <= xid_nxt;
            mac_q <= mac_nxt;
            rip_q <= rip_nxt;
            sip_q <= sip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        msg_nxt   = msg_q;
        idx_nxt   = idx;
        xid_nxt   = xid_q;
        mac_nxt   = mac_q;
        rip_nxt   = rip_q;
        sip_nxt   = sip_q;
        case (state)
            ST_IDLE: begin
                if (bus.send_discover || bus.send_request) begin
                    state_nxt = ST_REQ;
                    idx_nxt   = 9'd0;
                    mac_nxt   = bus.local_mac;
                    rip_nxt   = bus.requested_ip;
                    sip_nxt   = bus.server_ip;
                    // REQUEST reuses the xid of the preceding DISCOVER
                    if (bus.send_discover) begin
                        msg_nxt = MSG_DISCOVER;
                        xid_nxt = lfsr_val;
                    end else begin
                        msg_nxt = MSG_REQUEST;
                    end
                end
            end
            ST_REQ: begin
                if (bus.tx_enable) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (!bus.tx_enable) begin
                    state_nxt = ST_IDLE;
                end else if (bus.tx_next) begin
                    if (idx == LAST_IDX) state_nxt = ST_DONE;
                    else                 idx_nxt   = idx + 9'd1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_val = 8'h00;
        if (idx < 9'd243) begin
            case (idx)
                9'd0:   byte_val = BOOTP_OP_REQUEST;
                9'd1:   byte_val = BOOTP_HTYPE_ETH;
                9'd2:   byte_val = BOOTP_HLEN_ETH;
                9'd4:   byte_val = xid_q[31:24];
                9'd5:   byte_val = xid_q[23:16];
                9'd6:   byte_val = xid_q[15:8];
                9'd7:   byte_val = xid_q[7:0];
                9'd10:  byte_val = BOOTP_FLAGS_BCAST;
                9'd28:  byte_val = mac_q[47:40];
                9'd29:  byte_val = mac_q[39:32];
                9'd30:  byte_val = mac_q[31:24];
                9'd31:  byte_val = mac_q[23:16];
                9'd32:  byte_val = mac_q[15:8];
                9'd33:  byte_val = mac_q[7:0];
                9'd236: byte_val = MAGIC_COOKIE[31:24];
                9'd237: byte_val = MAGIC_COOKIE[23:16];
                9'd238: byte_val = MAGIC_COOKIE[15:8];
                9'd239: byte_val = MAGIC_COOKIE[7:0];
                9'd240: byte_val = OPT_MSG_TYPE;
                9'd241: byte_val = 8'd1;
                9'd242: byte_val = (msg_q == MSG_REQUEST) ? DHCP_REQUEST : DHCP_DISCOVER;
                default: byte_val = 8'h00;
            endcase
        end else if (msg_q == MSG_DISCOVER) begin
            case (idx)
                9'd243: byte_val = OPT_PARAM_LIST;
                9'd244: byte_val = 8'd3;
                9'd245: byte_val = PARAM_SUBNET;
                9'd246: byte_val = PARAM_ROUTER;
                9'd247: byte_val = PARAM_LEASE;
                9'd248: byte_val = OPT_END;
                default: byte_val = 8'h00;
            endcase
        end else begin
            case (idx)
                9'd243: byte_val = OPT_REQ_IP;
                9'd244: byte_val = 8'd4;
                9'd245: byte_val = rip_q[31:24];
                9'd246: byte_val = rip_q[23:16];
                9'd247: byte_val = rip_q[15:8];
                9'd248: byte_val = rip_q[7:0];
                9'd249: byte_val = OPT_SERVER_ID;
                9'd250: byte_val = 8'd4;
                9'd251: byte_val = sip_q[31:24];
                9'd252: byte_val = sip_q[23:16];
                9'd253: byte_val = sip_q[15:8];
                9'd254: byte_val = sip_q[7:0];
                9'd255: byte_val = OPT_PARAM_LIST;
                9'd256: byte_val = 8'd3;
                9'd257: byte_val = PARAM_SUBNET;
                9'd258: byte_val = PARAM_ROUTER;
                9'd259: byte_val = PARAM_LEASE;
                9'd260: byte_val = OPT_END;
                default: byte_val = 8'h00;
            endcase
        end
    end

    assign bus.tx_request = (state == ST_REQ);
    assign bus.active     = (state == ST_SEND);
    assign bus.done       = (state == ST_DONE);
    assign bus.tx_length  = 16'(PAYLOAD_LEN);
    assign bus.xid        = xid_q;
    // Only present payload bytes while a message is pending or streaming
    assign bus.tx_data    = (state == ST_REQ || state == ST_SEND) ? byte_val : 8'h00;

endmodule

// File: tb/tb_dhcp_send.sv
// Randomized scoreboard bench for dhcp_send against a byte-list model of the DHCP payload.
module tb_dhcp_send;
    import dhcp_pkg::*;

    localparam logic [31:0] SEED = 32'hA5C3_1E7B;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dhcp_send_if bif();

    dhcp_send #(.PAYLOAD_LEN(300), .XID_SEED(SEED)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [7:0]  sb[$];
    logic [31:0] m_lfsr;
    logic [31:0] m_xid = 32'h0;
    logic [31:0] exp_xid = 32'h0;
    bit          expect_done = 1'b0;
    logic [47:0] mac;
    logic [31:0] rip;
    logic [31:0] sip;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Polynomial x^32 + x^22 + x^2 + x + 1, shifted towards bit 0
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        logic [31:0] poly;
        poly = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
        return (x >> 1) ^ (x[0] ? poly : 32'h0);
    endfunction

    always @(posedge clock) begin
        if (!reset) m_lfsr = SEED;
        else        m_lfsr = lfsr_next(m_lfsr);
    end

    // Assemble the expected 300-byte payload field by field
    function automatic void push_model(input bit is_req, input logic [31:0] x,
                                       input logic [47:0] m, input logic [31:0] r,
                                       input logic [31:0] s);
        logic [7:0] q[$];
        q = {8'h01, 8'h01, 8'h06, 8'h00};
        for (int i = 3; i >= 0; i--) q.push_back(x[8*i +: 8]);
        q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h80); q.push_back(8'h00);
        repeat (16) q.push_back(8'h00);
        for (int i = 5; i >= 0; i--) q.push_back(m[8*i +: 8]);
        while (q.size() < 236) q.push_back(8'h00);
        q.push_back(8'h63); q.push_back(8'h82); q.push_back(8'h53); q.push_back(8'h63);
        q.push_back(8'h35); q.push_back(8'h01); q.push_back(is_req ? 8'h03 : 8'h01);
        if (is_req) begin
            q.push_back(8'h32); q.push_back(8'h04);
            for (int i = 3; i >= 0; i--) q.push_back(r[8*i +: 8]);
            q.push_back(8'h36); q.push_back(8'h04);
            for (int i = 3; i >= 0; i--) q.push_back(s[8*i +: 8]);
        end
        q.push_back(8'h37); q.push_back(8'h03); q.push_back(8'h01);
        q.push_back(8'h03); q.push_back(8'h33); q.push_back(8'hFF);
        while (q.size() < 300) q.push_back(8'h00);
        foreach (q[i]) sb.push_back(q[i]);
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            if (bif.tx_request || bif.active) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: DUT presents byte %0h, no byte expected (t=%0t)",
                             bif.tx_data, $time);
                end else begin
                    chk("tx_data", bif.tx_data, sb[0]);
                    chk("xid", bif.xid, exp_xid);
                    if (bif.active && bif.tx_enable && bif.tx_next) void'(sb.pop_front());
                end
            end
            if (bif.done) begin
                chk("done_expected", expect_done, 1);
                chk("done_all_bytes", sb.size(), 0);
                done_cnt++;
            end
        end
    end

    task automatic do_xfer(input bit disc, input bit req, input int grant_dly, input int pct,
                           input int stop_at, input bit stop_rst, input int retrig_at);
        int n;
        int cyc;
        int d0;
        bit prev_next;
        bit was_active;
        @(posedge clock); #1;
        bif.send_discover = disc;
        bif.send_request  = req;
        bif.local_mac     = mac;
        bif.requested_ip  = rip;
        bif.server_ip     = sip;
        if (disc) m_xid = m_lfsr;
        exp_xid = m_xid;
        push_model(!disc, exp_xid, mac, rip, sip);
        expect_done = (stop_at < 0);
        d0 = done_cnt;
        @(posedge clock); #1;
        bif.send_discover = 1'b0;
        bif.send_request  = 1'b0;
        bif.local_mac     = {16'($urandom), $urandom};
        bif.requested_ip  = $urandom;
        bif.server_ip     = $urandom;
        chk("tx_request_raised", bif.tx_request, 1);
        chk("active_in_req", bif.active, 0);
        repeat (grant_dly) begin @(posedge clock); #1; end
        bif.tx_enable = 1'b1;
        n = 0; cyc = 0; prev_next = 1'b0; was_active = 1'b0;
        forever begin
            @(posedge clock); #1;
            bif.send_discover = 1'b0;
            bif.send_request  = 1'b0;
            if (was_active && prev_next) n++;
            if (stop_at >= 0 && n == stop_at) break;
            was_active = bif.active;
            if (!was_active && n > 0) break;
            cyc++;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL timeout: %0d bytes consumed, required %0d", n, DHCP_LEN);
                break;
            end
            if (was_active && n == retrig_at) begin
                bif.send_discover = 1'b1;
                bif.send_request  = 1'b1;
            end
            prev_next   = ($urandom_range(99) < pct);
            bif.tx_next = prev_next;
        end
        bif.tx_next = 1'b0;
        if (stop_at >= 0) begin
            if (stop_rst) reset = 1'b0;
            else          bif.tx_enable = 1'b0;
            @(posedge clock); #1;
            chk("stop_active", bif.active, 0);
            chk("stop_done", bif.done, 0);
            chk("stop_tx_request", bif.tx_request, 0);
            if (stop_rst) begin
                chk("rst_xid", bif.xid, 0);
                chk("rst_tx_data", bif.tx_data, 0);
                m_xid = 32'h0;
                reset = 1'b1;
            end
            sb.delete();
        end
        bif.tx_enable = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("done_count", done_cnt - d0, expect_done ? 1 : 0);
        chk("sb_drained", sb.size(), 0);
        chk("idle_active", bif.active, 0);
        chk("idle_tx_request", bif.tx_request, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        bit d;
        bif.send_discover = 1'b0;
        bif.send_request  = 1'b0;
        bif.local_mac     = 48'h0;
        bif.requested_ip  = 32'h0;
        bif.server_ip     = 32'h0;
        bif.tx_enable     = 1'b0;
        bif.tx_next       = 1'b0;
        reset = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("rst_tx_request", bif.tx_request, 0);
        chk("rst_active", bif.active, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_tx_data", bif.tx_data, 0);
        chk("rst_xid", bif.xid, 0);
        chk("tx_length", bif.tx_length, 300);
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        chk("idle_tx_request_no_trigger", bif.tx_request, 0);

        mac = 48'h001C_C0A2_12DD; rip = 32'h0; sip = 32'h0;
        do_xfer(1'b1, 1'b0, 2, 100, -1, 1'b0, -1);
        rip = 32'hC0A8_0132; sip = 32'hC0A8_0101;
        do_xfer(1'b0, 1'b1, 2, 100, -1, 1'b0, -1);
        do_xfer(1'b1, 1'b1, 1, 100, -1, 1'b0, 50);
        mac = {16'($urandom), $urandom};
        do_xfer(1'b1, 1'b0, 3, 50, -1, 1'b0, -1);
        do_xfer(1'b0, 1'b1, 0, 100, 100, 1'b0, -1);
        do_xfer(1'b0, 1'b1, 1, 70, -1, 1'b0, -1);
        do_xfer(1'b1, 1'b0, 2, 100, 150, 1'b1, -1);
        do_xfer(1'b0, 1'b1, 1, 100, -1, 1'b0, -1);
        for (int k = 0; k < 4; k++) begin
            mac = {16'($urandom), $urandom};
            rip = $urandom;
            sip = $urandom;
            d = 1'($urandom_range(1));
            do_xfer(d, d ? 1'($urandom_range(1)) : 1'b1, $urandom_range(4),
                    $urandom_range(100, 30), -1, 1'b0, $urandom_range(299));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dhcp_send.md
Name: dhcp_send

Overview:
- Transmit side of DHCP client: builds DHCPDISCOVER and DHCPREQUEST payloads (BOOTP body + options) as a byte stream.
- Feeds the UDP send path (local port 68 → 67, broadcast) via request/enable handshake arbitrated by the network tx scheduler.
- Driven by the network state machine (ST_DHCP_REQUEST / ST_DHCP_RENEW); complements the DHCP receive path that yields dhcp_success / offered IP / server IP.

Parameters:
- PAYLOAD_LEN, 300, fixed payload length in bytes (zero padded after END option).
- XID_SEED, 32'hA5C3_1E7B, nonzero LFSR reset seed.

Ports:
- clock  in  1  tx_clock domain.
- reset  in  1  synchronous, active-low (0 = reset).
- send_discover  in  1  one-cycle trigger, build DISCOVER.
- send_request  in  1  one-cycle trigger, build REQUEST.
- local_mac  in  48  chaddr source.
- requested_ip  in  32  option 50 value (REQUEST only).
- server_ip  in  32  option 54 value (REQUEST only).
- tx_enable  in  1  grant from tx arbiter; high for whole transfer.
- tx_next  in  1  UDP sender consumed current tx_data byte.
- tx_request  out  1  payload ready, waiting for grant.
- tx_length  out  16  constant PAYLOAD_LEN.
- tx_data  out  8  current payload byte.
- active  out  1  streaming in progress.
- done  out  1  one-cycle pulse after last byte consumed.
- xid  out  32  transaction ID of current/last message (for receive-side match).

Behaviour:
- Reset (reset==0 at posedge): state IDLE, tx_request=0, active=0, done=0, tx_data=0, byte index=0, LFSR=XID_SEED, xid=0. tx_length always 16'd300.
- LFSR: 32-bit Galois, taps 32,22,2,1; advances every cycle outside reset.
- States: IDLE → REQ → SEND → DONE → IDLE.
- IDLE: send_discover → msg=DISCOVER, xid<=LFSR; else send_request → msg=REQUEST, xid unchanged (reuse DISCOVER xid). Both high same cycle: DISCOVER wins. Go REQ; tx_request=1 next cycle. Index=0, tx_data=byte0 (8'h01).
- Triggers outside IDLE ignored (no queueing).
- REQ: hold tx_request, tx_data=byte0. tx_enable sampled 1 → SEND, tx_request=0, active=1 next cycle.
- SEND: tx_next=1 → index+1, tx_data=byte[index+1] next cycle; tx_next=0 holds. tx_next with index=299 → DONE, active=0.
- DONE: done=1 for one cycle → IDLE.
- tx_enable drops in SEND before the last byte: abort → IDLE next cycle, active=0, no done.
- Byte map (index: value): 0:01, 1:01, 2:06, 3:00, 4-7:xid MSB first, 8-9:00, 10-11:80 00 (broadcast flag), 12-27:00 (ciaddr/yiaddr/siaddr/giaddr), 28-33:local_mac MSB first, 34-235:00, 236-239:63 82 53 63.
- DISCOVER options: 240-242: 35 01 01; 243-247: 37 03 01 03 33; 248: FF; 249-299: 00.
- REQUEST options: 240-242: 35 01 03; 243-248: 32 04 requested_ip; 249-254: 36 04 server_ip; 255-259: 37 03 01 03 33; 260: FF; 261-299: 00.
- local_mac, requested_ip, server_ip are sampled on the IDLE trigger; later input changes do not alter an in-flight message.
- Index: 9-bit, never wraps past 299.

Decomposition:
- Package dhcp_pkg: DHCP_LEN=300, BOOTP op/htype/hlen, MAGIC_COOKIE=32'h63825363, option codes (53,50,54,55,255), message types (DISCOVER=1, REQUEST=3), ports 67/68, state enum.
- Sub-module dhcp_xid_lfsr: free-running 32-bit LFSR with seed parameter.
- Byte map: single combinational case on index/msg inside dhcp_send.

Test Plan:
- DISCOVER, local_mac=00:1C:C0:A2:12:DD, tx_enable 2 cycles after tx_request, tx_next every cycle → 300 bytes; 28-33 = 00 1C C0 A2 12 DD; 240-248 = 35 01 01 37 03 01 03 33 FF; rest zero; one done pulse.
- REQUEST after DISCOVER, requested_ip=192.168.1.50, server_ip=192.168.1.1 → same xid bytes 4-7; 243-254 = 32 04 C0 A8 01 32 36 04 C0 A8 01 01; 260=FF.
- send_discover and send_request in the same cycle → byte 242 = 01; retrigger while active ignored; stream unchanged.
- tx_next gated randomly (~50%) → tx_data holds between pulses; byte sequence identical to the contiguous case.
- tx_enable dropped at index 100 → IDLE next cycle, active=0, no done; a new trigger restarts at byte 0.
- reset=0 at index 150 → all outputs at reset values next cycle; xid=0; tx_request stays 0 with no trigger.
